fabric_gsr_sequencer: RTL and testbench
=======================================

// Module: fabric_gsr_sequencer
// PURPOSE
//  Sequences the fabric-wide global set/reset/clock-enable nets that drive every CLB ff (DFFSRQ) primitive.
//  After the bitstream is loaded it holds all ffs in reset, releases them and then enables the fabric clock.
//  In run mode it serves user set/reset pulse requests with a req/ack handshake.
//  The clock is gated while set or reset is asserted, and set and reset are never asserted together.
//  Sits between the configuration controller and the fabric global ports.
// PARAMETERS
//  RST_CYCLES     16  cycles fab_reset held after cfg_done rises (>=1)
//  SETTLE_CYCLES  4   cycles between set/reset deassert and clk_en assert (>=1)
//  PULSE_CYCLES   2   width of a requested set/reset pulse (>=1)
//  CNT_W          $clog2(max(RST,SETTLE,PULSE)+1)  internal counter width (derived, localparam)
// PORTS
//  clk        in   1  fabric clock; the only clock
//  reset      in   1  synchronous, ACTIVE-LOW block reset
//  cfg_done   in   1  bitstream loaded, level, synchronous to clk
//  req_rst    in   1  request a fabric reset pulse, level; held until ack
//  req_set    in   1  request a fabric set pulse, level; held until ack
//  ack        out  1  one-cycle pulse: request serviced
//  fab_set    out  1  to global set of all ffs, active-high
//  fab_reset  out  1  to global reset of all ffs, active-high
//  fab_clk_en out  1  enable to fabric clock gate
//  ready      out  1  fabric running (state RUN)
// BEHAVIOUR
//  All outputs registered. Reset (reset==0 at a clk edge) forces state UNCFG:
//   fab_reset=1, fab_set=0, fab_clk_en=0, ready=0, ack=0, counter=0.
//  States / transitions (counter loads on entry, counts down, exits at 1):
//   UNCFG : fab_reset=1; cfg_done==1 -> HOLD (cnt=RST_CYCLES)
//   HOLD  : fab_reset=1 for exactly RST_CYCLES cycles -> SETTLE
//   SETTLE: set=reset=0, clk_en=0 for SETTLE_CYCLES cycles -> RUN
//   RUN   : clk_en=1, ready=1; req_rst -> PRST; else req_set -> PSET
//   PRST  : fab_reset=1, clk_en=0 for PULSE_CYCLES -> SETTLE (tagged)
//   PSET  : fab_set=1, clk_en=0 for PULSE_CYCLES -> SETTLE (tagged)
//  ack pulses for one cycle on the SETTLE->RUN edge after a tagged pulse only
//   (not after the power-up sequence). Requester must drop req on ack; a req still high
//   in the cycle after ack is treated as a new request.
//  Latency: cfg_done rise to ready = 1+RST_CYCLES+SETTLE_CYCLES cycles (default 21).
//  Request in RUN to ack = 1+PULSE_CYCLES+SETTLE_CYCLES cycles (default 7).
//  fab_clk_en drops in the same cycle fab_set/fab_reset rises (both registered from next state).
//  Boundary rules:
//   - req_rst and req_set both high in RUN: reset wins, set remains pending and is served next.
//   - requests outside RUN are ignored until RUN (level, so not lost).
//   - cfg_done falls in any state other than UNCFG: go to UNCFG next cycle, drop any tag, no ack.
//   - block reset mid-sequence: immediate UNCFG, outputs per reset values.
//   - fab_set and fab_reset are never both 1 (assertion in bench).
// STRUCTURE
//  Package fabric_gsr_pkg: state enum (UNCFG, HOLD, SETTLE, RUN, PRST, PSET) and default cycle constants.
//  One natural sub-module: gsr_down_counter (load/dec/is_one, width CNT_W).
//  The FSM, tag flop and output registers stay in the top-level block.
// TESTING
//  1. Hold reset low 3 cycles, cfg_done=0 -> fab_reset=1, fab_clk_en=0, ready=0.
//     Keep cfg_done=0 for 50 cycles -> no change.
//  2. Raise cfg_done at cycle T -> fab_reset=1 until T+17, fab_clk_en=1 and ready=1 at T+21, ack never pulses.
//  3. In RUN, raise req_set for 1 cycle at R -> fab_set=1 for 2 cycles, fab_clk_en=0, ack at R+7.
//     fab_reset stays 0 throughout.
//  4. In RUN, raise req_rst and req_set together and hold each until its ack ->
//     reset pulse first, first ack, then set pulse, second ack 7 cycles later.
//  5. Drop cfg_done during PRST -> UNCFG next cycle (fab_reset=1, ready=0), no ack.
//     Raising cfg_done again repeats the 21-cycle power-up.
//  6. Pull reset low during HOLD and during RUN -> next cycle has all reset values.
//     Run random req traffic and check that fab_set&fab_reset is never 1.

Source files
------------

// File: rtl/fabric_gsr_pkg.sv
// Shared state encoding, default sequencing lengths and counter sizing for the
// fabric global set/reset sequencer.
package fabric_gsr_pkg;

  typedef enum logic [2:0] {
    UNCFG  = 3'd0,
    HOLD   = 3'd1,
    SETTLE = 3'd2,
    RUN    = 3'd3,
    PRST   = 3'd4,
    PSET   = 3'd5
  } gsr_state_e;

  localparam int unsigned DEF_RST_CYCLES    = 16;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_CYCLES  = 2;

  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/fabric_gsr_sequencer_counter.sv
// Loadable down counter timing each phase of the global set/reset sequence.
module gsr_down_counter #(
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] load_val,
  output logic             is_one
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign is_one = (cnt == CNT_W'(1));

endmodule

// File: rtl/fabric_gsr_sequencer.sv
// Power-up and run-time sequencer for the fabric-wide set/reset/clock-enable nets
// that drive every CLB flip-flop.
module fabric_gsr_sequencer
  import fabric_gsr_pkg::*;
#(
  parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned PULSE_CYCLES  = DEF_PULSE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic cfg_done,
  input  logic req_rst,
  input  logic req_set,
  output logic ack,
  output logic fab_set,
  output logic fab_reset,
  output logic fab_clk_en,
  output logic ready
);

  localparam int unsigned CNT_W = cnt_width(RST_CYCLES, SETTLE_CYCLES, PULSE_CYCLES);

  gsr_state_e       state;
  gsr_state_e       nstate;
  logic             tag;
  logic             ack_nxt;
  logic             cnt_load;
  logic             cnt_dec;
  logic             cnt_one;
  logic [CNT_W-1:0] cnt_val;

  gsr_down_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (cnt_val),
    .is_one   (cnt_one)
  );

  // Losing cfg_done overrides every other transition, including a pending pulse.
  always_comb begin
    nstate = state;
    if (state != UNCFG && !cfg_done) begin
      nstate = UNCFG;
    end else begin
      case (state)
        UNCFG:      if (cfg_done) nstate = HOLD;
        HOLD:       if (cnt_one)  nstate = SETTLE;
        SETTLE:     if (cnt_one)  nstate = RUN;
        RUN: begin
          if (req_rst)      nstate = PRST;
          else if (req_set) nstate = PSET;
        end
        PRST, PSET: if (cnt_one)  nstate = SETTLE;
        default:                  nstate = UNCFG;
      endcase
    end
  end

  always_comb begin
    cnt_val  = '0;
    cnt_load = 1'b0;
    if (nstate != state) begin
      case (nstate)
        HOLD:       begin cnt_load = 1'b1; cnt_val = CNT_W'(RST_CYCLES);    end
        SETTLE:     begin cnt_load = 1'b1; cnt_val = CNT_W'(SETTLE_CYCLES); end
        PRST, PSET: begin cnt_load = 1'b1; cnt_val = CNT_W'(PULSE_CYCLES);  end
        default:    cnt_load = 1'b0;
      endcase
    end
    cnt_dec = !cnt_load && !cnt_one &&
              (state == HOLD || state == SETTLE || state == PRST || state == PSET);
    ack_nxt = tag && (state == SETTLE) && (nstate == RUN);
  end

  // Outputs are registered from the next state so clk_en falls with set/reset rising.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= UNCFG;
      tag        <= 1'b0;
      ack        <= 1'b0;
      fab_set    <= 1'b0;
      fab_reset  <= 1'b1;
      fab_clk_en <= 1'b0;
      ready      <= 1'b0;
    end else begin
      state      <= nstate;
      ack        <= ack_nxt;
      fab_set    <= (nstate == PSET);
      fab_reset  <= (nstate == UNCFG) || (nstate == HOLD) || (nstate == PRST);
      fab_clk_en <= (nstate == RUN);
      ready      <= (nstate == RUN);
      if (nstate == PRST || nstate == PSET) begin
        tag <= 1'b1;
      end else if (nstate == UNCFG || ack_nxt) begin
        tag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fabric_gsr_sequencer.sv
// Scoreboard bench for fabric_gsr_sequencer: expected ack cycles are queued when
// requests are driven and consumed by the ack monitor.
module tb_fabric_gsr_sequencer;
  import fabric_gsr_pkg::*;

  localparam int RST = DEF_RST_CYCLES;
  localparam int STL = DEF_SETTLE_CYCLES;
  localparam int PUL = DEF_PULSE_CYCLES;
  localparam int REQ_LAT = 1 + PUL + STL;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cfg_done = 1'b0;
  logic req_rst = 1'b0;
  logic req_set = 1'b0;
  logic ack, fab_set, fab_reset, fab_clk_en, ready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_ack_q[$];

  fabric_gsr_sequencer #(
    .RST_CYCLES    (RST),
    .SETTLE_CYCLES (STL),
    .PULSE_CYCLES  (PUL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_done   (cfg_done),
    .req_rst    (req_rst),
    .req_set    (req_set),
    .ack        (ack),
    .fab_set    (fab_set),
    .fab_reset  (fab_reset),
    .fab_clk_en (fab_clk_en),
    .ready      (ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    checks++;
    if ((fab_set & fab_reset) !== 1'b0) begin
      failures++;
      $display("FAIL set_reset_overlap cyc=%0d set=%b reset=%b", cyc, fab_set, fab_reset);
    end
    if (ack === 1'b1) begin
      checks++;
      if (exp_ack_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack cyc=%0d (no ack expected)", cyc);
      end else begin
        int e;
        e = exp_ack_q.pop_front();
        if (cyc !== e) begin
          failures++;
          $display("FAIL ack_cycle got=%0d expected=%0d", cyc, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    reset = 1'b0;
    cfg_done = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fab_reset, fab_set, fab_clk_en, ready, ack} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_state got=%b expected=10000", {fab_reset, fab_set, fab_clk_en, ready, ack});
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checks++;
      if ({fab_reset, fab_set, fab_clk_en, ready, ack} !== 5'b10000) begin
        failures++;
        $display("FAIL uncfg_idle i=%0d got=%b expected=10000", i, {fab_reset, fab_set, fab_clk_en, ready, ack});
      end
    end
  endtask

  task automatic test_powerup();
    int t;
    logic exp_rst, exp_rdy;
    t = cyc;
    reset = 1'b1;
    cfg_done = 1'b1;
    for (int i = 1; i <= 1 + RST + STL + 1; i++) begin
      @(negedge clk);
      exp_rst = ((cyc - t) <= RST);
      exp_rdy = ((cyc - t) >= 1 + RST + STL);
      checks++;
      if ({fab_reset, fab_set, fab_clk_en, ready} !== {exp_rst, 1'b0, exp_rdy, exp_rdy}) begin
        failures++;
        $display("FAIL powerup i=%0d got rst/set/en/rdy=%b expected=%b", cyc - t,
                 {fab_reset, fab_set, fab_clk_en, ready}, {exp_rst, 1'b0, exp_rdy, exp_rdy});
      end
    end
  endtask

  task automatic test_set_pulse();
    int r;
    logic exp_set, exp_en;
    r = cyc;
    req_set = 1'b1;
    exp_ack_q.push_back(r + REQ_LAT);
    for (int i = 1; i <= REQ_LAT + 2; i++) begin
      @(negedge clk);
      req_set = 1'b0;
      exp_set = (i >= 1) && (i <= PUL);
      exp_en  = (i >= REQ_LAT);
      checks++;
      if ({fab_reset, fab_set, fab_clk_en} !== {1'b0, exp_set, exp_en}) begin
        failures++;
        $display("FAIL set_pulse i=%0d got rst/set/en=%b expected=%b", i,
                 {fab_reset, fab_set, fab_clk_en}, {1'b0, exp_set, exp_en});
      end
    end
    checks++;
    if (exp_ack_q.size() != 0) begin
      failures++;
      $display("FAIL set_ack_missing pending=%0d expected=0", exp_ack_q.size());
    end
  endtask

  task automatic test_both_req();
    int r, seen;
    logic exp_rst, exp_set, exp_en;
    r = cyc;
    seen = 0;
    req_rst = 1'b1;
    req_set = 1'b1;
    exp_ack_q.push_back(r + REQ_LAT);
    exp_ack_q.push_back(r + 2 * REQ_LAT);
    for (int i = 1; i <= 2 * REQ_LAT + 2; i++) begin
      @(negedge clk);
      exp_rst = (i >= 1) && (i <= PUL);
      exp_set = (i >= REQ_LAT + 1) && (i <= REQ_LAT + PUL);
      exp_en  = (i == REQ_LAT) || (i >= 2 * REQ_LAT);
      checks++;
      if ({fab_reset, fab_set, fab_clk_en} !== {exp_rst, exp_set, exp_en}) begin
        failures++;
        $display("FAIL both_req i=%0d got rst/set/en=%b expected=%b", i,
                 {fab_reset, fab_set, fab_clk_en}, {exp_rst, exp_set, exp_en});
      end
      if (ack === 1'b1) begin
        seen++;
        if (seen == 1) req_rst = 1'b0;
        else req_set = 1'b0;
      end
    end
    req_rst = 1'b0;
    req_set = 1'b0;
    checks++;
    if (seen != 2 || exp_ack_q.size() != 0) begin
      failures++;
      $display("FAIL both_acks got=%0d pending=%0d expected=2 pending=0", seen, exp_ack_q.size());
    end
  endtask

  task automatic test_cfg_drop();
    req_rst = 1'b1;
    @(negedge clk);
    req_rst = 1'b0;
    checks++;
    if ({fab_reset, fab_clk_en} !== 2'b10) begin
      failures++;
      $display("FAIL prst_entry got rst/en=%b expected=10", {fab_reset, fab_clk_en});
    end
    cfg_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({fab_reset, fab_set, fab_clk_en, ready} !== 4'b1000) begin
        failures++;
        $display("FAIL cfg_drop i=%0d got=%b expected=1000", i, {fab_reset, fab_set, fab_clk_en, ready});
      end
    end
    test_powerup();
  endtask

  task automatic test_reset_mid();
    req_set = 1'b1;
    @(negedge clk);
    req_set = 1'b0;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if ({fab_reset, fab_set, fab_clk_en, ready, ack} !== 5'b10000) begin
        failures++;
        $display("FAIL reset_in_run i=%0d got=%b expected=10000", i, {fab_reset, fab_set, fab_clk_en, ready, ack});
      end
    end
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({fab_reset, fab_set, fab_clk_en, ready, ack} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_in_hold got=%b expected=10000", {fab_reset, fab_set, fab_clk_en, ready, ack});
    end
    test_powerup();
  endtask

  task automatic test_random();
    int r, kind, need, seen;
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(1, 3)) @(negedge clk);
      checks++;
      if (ready !== 1'b1) begin
        failures++;
        $display("FAIL rand_ready t=%0d got=%b expected=1", t, ready);
      end
      kind = $urandom_range(0, 2);
      r = cyc;
      req_rst = (kind != 1);
      req_set = (kind != 0);
      need = (kind == 2) ? 2 : 1;
      exp_ack_q.push_back(r + REQ_LAT);
      if (need == 2) exp_ack_q.push_back(r + 2 * REQ_LAT);
      seen = 0;
      for (int w = 0; w < 4 * REQ_LAT && seen < need; w++) begin
        @(negedge clk);
        if (ack === 1'b1) begin
          seen++;
          if (req_rst) req_rst = 1'b0;
          else req_set = 1'b0;
        end
      end
      req_rst = 1'b0;
      req_set = 1'b0;
      checks++;
      if (seen != need) begin
        failures++;
        $display("FAIL rand_acks t=%0d kind=%0d got=%0d expected=%0d", t, kind, seen, need);
      end
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_set_pulse();
    test_both_req();
    test_cfg_drop();
    test_reset_mid();
    test_random();
    repeat (3) @(negedge clk);
    checks++;
    if (exp_ack_q.size() != 0) begin
      failures++;
      $display("FAIL final_pending got=%0d expected=0", exp_ack_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
